ysyx_24110006_hazard_scoreboard: RTL

YSYX_24110006_HAZARD_SCOREBOARD -- requirements
Module: ysyx_24110006_hazard_scoreboard

---
 rtl/ysyx_24110006_pipe_pkg.sv | 32 +++
 rtl/ysyx_24110006_hazard_scoreboard_if.sv | 51 +++++
 rtl/ysyx_24110006_rs_use_decode.sv | 34 +++
 rtl/ysyx_24110006_hazard_scoreboard.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/ysyx_24110006_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ysyx_24110006_pipe_pkg                                                     |
// | Shared pipeline constants: RV opcodes, scoreboard defaults, fw sources.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ysyx_24110006_pipe_pkg;

    localparam int PKG_NREG = 32;
    localparam int PKG_PW   = 2;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Forwarding source slots, youngest first.
    typedef enum int unsigned {
        FW_EXU = 0,
        FW_LSU = 1,
        FW_WBU = 2
    } fw_src_e;

endpackage
`default_nettype wire

// File: rtl/ysyx_24110006_hazard_scoreboard_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ysyx_24110006_hazard_scoreboard_if                                         |
// | Issue/forward/writeback bundle between the pipeline and the scoreboard.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface ysyx_24110006_hazard_scoreboard_if #(
    parameter int NREG = 32,
    parameter int NSRC = 3,
    parameter int NRS  = 2,
    parameter int XLEN = 32
);
    localparam int RW = $clog2(NREG);

    logic                   i_valid;
    logic                   i_issue_ready;
    logic [6:0]             i_op;
    logic [NRS*RW-1:0]      i_rs;
    logic [NRS*XLEN-1:0]    i_reg_src;
    logic [RW-1:0]          i_rd;
    logic                   i_wen;
    logic [NSRC-1:0]        i_fw_valid;
    logic [NSRC-1:0]        i_fw_wen;
    logic [NSRC-1:0]        i_fw_dready;
    logic [NSRC*RW-1:0]     i_fw_rd;
    logic [NSRC*XLEN-1:0]   i_fw_data;
    logic                   i_wb_valid;
    logic                   i_wb_wen;
    logic [RW-1:0]          i_wb_rd;
    logic                   i_flush;
    logic                   i_perf_clr;
    logic [NRS*XLEN-1:0]    o_src;
    logic                   o_stall;
    logic [31:0]            o_stall_cycles;
    logic                   o_sb_err;

    modport master (
        output i_valid, i_issue_ready, i_op, i_rs, i_reg_src, i_rd, i_wen,
        output i_fw_valid, i_fw_wen, i_fw_dready, i_fw_rd, i_fw_data,
        output i_wb_valid, i_wb_wen, i_wb_rd, i_flush, i_perf_clr,
        input  o_src, o_stall, o_stall_cycles, o_sb_err
    );

    modport slave (
        input  i_valid, i_issue_ready, i_op, i_rs, i_reg_src, i_rd, i_wen,
        input  i_fw_valid, i_fw_wen, i_fw_dready, i_fw_rd, i_fw_data,
        input  i_wb_valid, i_wb_wen, i_wb_rd, i_flush, i_perf_clr,
        output o_src, o_stall, o_stall_cycles, o_sb_err
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_24110006_rs_use_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ysyx_24110006_rs_use_decode                                                |
// | Which source-register ports an opcode actually reads.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ysyx_24110006_rs_use_decode
    import ysyx_24110006_pipe_pkg::*;
#(
    parameter int NRS = 2
) (
    input  wire logic [6:0]     i_op,
    output logic      [NRS-1:0] o_rs_use
);
    logic [1:0] w_pair;

    always_comb begin
        w_pair = 2'b00;
        case (i_op)
            OPC_JALR, OPC_OP_IMM, OPC_LOAD, OPC_SYSTEM: w_pair = 2'b01;
            OPC_OP, OPC_STORE, OPC_BRANCH:              w_pair = 2'b11;
            default:                                    w_pair = 2'b00;
        endcase
    end

    // Ports beyond rs2 are never read by the base ISA.
    always_comb begin
        o_rs_use = '0;
        for (int p = 0; p < NRS && p < 2; p++) begin
            o_rs_use[p] = w_pair[p];
        end
    end
endmodule
`default_nettype wire

// File: rtl/ysyx_24110006_hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ysyx_24110006_hazard_scoreboard                                            |
// | Operand forwarding, pending-write scoreboard and issue stall generation.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ysyx_24110006_hazard_scoreboard
    import ysyx_24110006_pipe_pkg::*;
#(
    parameter int NREG = PKG_NREG,
    parameter int NSRC = 3,
    parameter int NRS  = 2,
    parameter int PW   = PKG_PW,
    parameter int XLEN = 32
) (
    input  wire logic clock,
    input  wire logic reset,
    ysyx_24110006_hazard_scoreboard_if.slave bus
);
    localparam int            RW         = $clog2(NREG);
    localparam logic [PW-1:0] C_PEND_MAX = '1;

    logic [PW-1:0]       pend_q [NREG];
    logic [PW-1:0]       pend_d [NREG];
    logic [PW-1:0]       w_pend [NREG];
    logic [31:0]         stall_cycles_q, stall_cycles_d;
    logic                sb_err_q, sb_err_d;
    logic [NRS-1:0]      w_rs_use;
    logic [NRS-1:0]      w_port_haz;
    logic [NRS*XLEN-1:0] w_src;
    logic                w_rd_full;
    logic                w_stall;
    logic                w_fire;

    ysyx_24110006_rs_use_decode #(.NRS(NRS)) u_rs_use (
        .i_op     (bus.i_op),
        .o_rs_use (w_rs_use)
    );

    // Counters read as zero while reset is held so outputs are defined then.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            w_pend[r] = reset ? '0 : pend_q[r];
        end
    end

    always_comb begin
        logic [RW-1:0]   v_rs;
        logic            v_hit;
        logic            v_ready;
        logic [XLEN-1:0] v_data;
        w_src      = bus.i_reg_src;
        w_port_haz = '0;
        v_rs       = '0;
        v_hit      = 1'b0;
        v_ready    = 1'b0;
        v_data     = '0;
        for (int p = 0; p < NRS; p++) begin
            v_rs    = bus.i_rs[p*RW +: RW];
            v_hit   = 1'b0;
            v_ready = 1'b0;
            v_data  = '0;
            // Oldest to youngest so the youngest match is the one that sticks.
            for (int k = NSRC - 1; k >= 0; k--) begin
                if (bus.i_fw_valid[k] && bus.i_fw_wen[k] &&
                    bus.i_fw_rd[k*RW +: RW] == v_rs) begin
                    v_hit   = 1'b1;
                    v_ready = bus.i_fw_dready[k];
                    v_data  = bus.i_fw_data[k*XLEN +: XLEN];
                end
            end
            if (v_rs != '0) begin
                if (v_hit) begin
                    if (v_ready) begin
                        w_src[p*XLEN +: XLEN] = v_data;
                    end else begin
                        w_port_haz[p] = 1'b1;
                    end
                end else if (w_pend[v_rs] != '0) begin
                    w_port_haz[p] = 1'b1;
                end
            end
        end
    end

    assign w_rd_full = bus.i_wen && (bus.i_rd != '0) && (w_pend[bus.i_rd] == C_PEND_MAX);
    assign w_stall   = bus.i_valid && ((|(w_port_haz & w_rs_use)) || w_rd_full);
    assign w_fire    = bus.i_valid && bus.i_issue_ready && !w_stall;

    always_comb begin
        logic v_inc;
        logic v_dec;
        sb_err_d = sb_err_q;
        v_inc    = 1'b0;
        v_dec    = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            pend_d[r] = pend_q[r];
        end
        if (bus.i_flush) begin
            for (int r = 0; r < NREG; r++) begin
                pend_d[r] = '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                v_inc = w_fire && bus.i_wen && (bus.i_rd == RW'(r));
                v_dec = bus.i_wb_valid && bus.i_wb_wen && (bus.i_wb_rd == RW'(r));
                if (v_inc && !v_dec) begin
                    pend_d[r] = pend_q[r] + 1'b1;
                end else if (v_dec && !v_inc) begin
                    if (pend_q[r] == '0) begin
                        sb_err_d = 1'b1;
                    end else begin
                        pend_d[r] = pend_q[r] - 1'b1;
                    end
                end
            end
        end
        pend_d[0] = '0;
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (bus.i_perf_clr) begin
            stall_cycles_d = '0;
        end else if (w_stall && stall_cycles_q != 32'hFFFF_FFFF) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                pend_q[r] <= '0;
            end
            stall_cycles_q <= '0;
            sb_err_q       <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                pend_q[r] <= pend_d[r];
            end
            stall_cycles_q <= stall_cycles_d;
            sb_err_q       <= sb_err_d;
        end
    end

    assign bus.o_src          = w_src;
    assign bus.o_stall        = w_stall;
    assign bus.o_stall_cycles = stall_cycles_q;
    assign bus.o_sb_err       = sb_err_q;
endmodule
`default_nettype wire
